fifo_rr_arbiter: RTL and testbench

Round-robin write arbiter that shares one FWFT FIFO write port among NREQ producers. Each producer offers one data word per cycle. A granted producer may hold the FIFO for up to MAX_BURST consecutive beats before ownership rotates. The block sits directly in front of the FIFO's `write`/`din`/`full` pins and tags every accepted word with the source index.

---
 rtl/fifo_rr_arbiter_if.sv | 38 +++
 rtl/fifo_rr_arbiter.sv | 140 ++++++++++++++
 tb/tb_fifo_rr_arbiter.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rr_arbiter_if.sv
// rtl/fifo_rr_arbiter_if.sv - producer/FIFO-side bus of the round-robin write arbiter
//
// Purpose: bundles the requester handshake and the FIFO write-port signals.
// Ports:
//   req        per-requester valid (NREQ)
//   data       flattened payloads, requester i at [i*DWIDTH +: DWIDTH]
//   gnt        one-hot or zero grant (NREQ)
//   fifo_full  FIFO full flag
//   fifo_write FIFO write strobe
//   fifo_din   granted payload (DWIDTH)
//   fifo_id    granted requester index (IDW)
//   busy       arbiter is locked to an owner
// Modports: master = producers/FIFO side, slave = arbiter side.

interface fifo_rr_arbiter_if #(
  parameter int NREQ   = 4,
  parameter int DWIDTH = 32,
  parameter int IDW    = $clog2(NREQ)
) ();
  logic [NREQ-1:0]        req;
  logic [NREQ*DWIDTH-1:0] data;
  logic [NREQ-1:0]        gnt;
  logic                   fifo_full;
  logic                   fifo_write;
  logic [DWIDTH-1:0]      fifo_din;
  logic [IDW-1:0]         fifo_id;
  logic                   busy;

  modport master (
    output req, data, fifo_full,
    input  gnt, fifo_write, fifo_din, fifo_id, busy
  );

  modport slave (
    input  req, data, fifo_full,
    output gnt, fifo_write, fifo_din, fifo_id, busy
  );
endinterface

// File: rtl/fifo_rr_arbiter.sv
// rtl/fifo_rr_arbiter.sv - round-robin burst arbiter sharing one FIFO write port
//
// Purpose: grants one of NREQ producers per cycle onto a FWFT FIFO write port.
// An owner keeps the port for up to MAX_BURST beats, then priority rotates.
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    fifo_rr_arbiter_if.slave (req/data in, gnt/fifo_* out, busy out)

module fifo_rr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DWIDTH    = 32,
  parameter int MAX_BURST = 4,
  parameter int IDW       = $clog2(NREQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  fifo_rr_arbiter_if.slave bus
);

  localparam int CW  = $clog2(MAX_BURST + 1);
  localparam int IW1 = IDW + 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t            state;
  logic [IDW-1:0]    rr_ptr;
  logic [IDW-1:0]    owner;
  logic [CW-1:0]     cnt;
  logic              busy_q;

  logic              win_found;
  logic [IDW-1:0]    win_idx;
  logic [IW1-1:0]    idx_w;
  logic              grant_vld;
  logic [IDW-1:0]    grant_idx;
  logic [NREQ-1:0]   gnt_w;
  logic [DWIDTH-1:0] din_w;
  logic [CW-1:0]     cnt_inc;

  // Explicit wrap at NREQ so non-power-of-2 requester counts rotate correctly.
  function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] x);
    if (x == IDW'(NREQ - 1))
      return '0;
    else
      return x + 1'b1;
  endfunction

  assign cnt_inc = cnt + CW'(1);

  // Circular priority scan starting at rr_ptr. The sum is one bit wider than
  // IDW so it cannot overflow before the modulo-NREQ correction.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    idx_w     = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx_w = {1'b0, rr_ptr} + IW1'(k);
      if (idx_w >= IW1'(NREQ))
        idx_w = idx_w - IW1'(NREQ);
      if (!win_found && bus.req[idx_w[IDW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = idx_w[IDW-1:0];
      end
    end
  end

  // Grant is gated by rst_n so that asserting reset kills the write strobe
  // immediately, even though IDLE with rr_ptr=0 would otherwise grant.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    if (rst_n && !bus.fifo_full) begin
      if (state == IDLE) begin
        grant_vld = win_found;
        grant_idx = win_idx;
      end else if (bus.req[owner]) begin
        grant_vld = 1'b1;
        grant_idx = owner;
      end
    end
  end

  always_comb begin
    gnt_w = '0;
    din_w = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_vld && grant_idx == IDW'(i)) begin
        gnt_w[i] = 1'b1;
        din_w    = bus.data[i*DWIDTH +: DWIDTH];
      end
    end
  end

  assign bus.gnt        = gnt_w;
  assign bus.fifo_write = grant_vld;
  assign bus.fifo_din   = din_w;
  assign bus.fifo_id    = grant_vld ? grant_idx : '0;
  assign bus.busy       = busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      rr_ptr <= '0;
      owner  <= '0;
      cnt    <= '0;
      busy_q <= 1'b0;
    end else if (state == IDLE) begin
      // A full FIFO leaves every register untouched so arbitration is redone.
      if (win_found && !bus.fifo_full) begin
        owner <= win_idx;
        cnt   <= CW'(1);
        if (MAX_BURST == 1) begin
          rr_ptr <= next_idx(win_idx);
        end else begin
          state  <= LOCKED;
          busy_q <= 1'b1;
        end
      end
    end else begin
      if (bus.req[owner]) begin
        // Full FIFO stalls the owner without releasing the lock.
        if (!bus.fifo_full) begin
          cnt <= cnt_inc;
          if (cnt_inc == CW'(MAX_BURST)) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            rr_ptr <= next_idx(owner);
          end
        end
      end else begin
        // Owner dropped its request: release, costing one bubble cycle.
        state  <= IDLE;
        busy_q <= 1'b0;
        rr_ptr <= next_idx(owner);
      end
    end
  end

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// tb/tb_fifo_rr_arbiter.sv - self-checking bench for fifo_rr_arbiter
module tb_fifo_rr_arbiter;
  localparam int NREQ      = 4;
  localparam int DWIDTH    = 32;
  localparam int MAX_BURST = 4;
  localparam int IDW       = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_rr_arbiter_if #(.NREQ(NREQ), .DWIDTH(DWIDTH), .IDW(IDW)) bus ();

  fifo_rr_arbiter #(
    .NREQ(NREQ), .DWIDTH(DWIDTH), .MAX_BURST(MAX_BURST), .IDW(IDW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: ownership view of the arbiter.
  bit m_locked;
  int m_owner;
  int m_beats;
  int m_ptr;

  logic [NREQ-1:0]   last_gnt;
  logic [IDW-1:0]    last_id;
  logic [DWIDTH-1:0] last_din;
  logic              last_busy;
  logic              last_write;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_locked = 1'b0;
    m_owner  = 0;
    m_beats  = 0;
    m_ptr    = 0;
  endtask

  function automatic int model_winner();
    if (!rst_n || bus.fifo_full) return -1;
    if (m_locked) return bus.req[m_owner] ? m_owner : -1;
    for (int k = 0; k < NREQ; k++) begin
      if (bus.req[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic model_step();
    int w;
    w = model_winner();
    if (!m_locked) begin
      if (w >= 0) begin
        m_owner = w;
        m_beats = 1;
        if (MAX_BURST == 1) m_ptr = (w + 1) % NREQ;
        else m_locked = 1'b1;
      end
    end else if (bus.req[m_owner]) begin
      if (!bus.fifo_full) begin
        m_beats++;
        if (m_beats == MAX_BURST) begin
          m_locked = 1'b0;
          m_ptr = (m_owner + 1) % NREQ;
        end
      end
    end else begin
      m_locked = 1'b0;
      m_ptr = (m_owner + 1) % NREQ;
    end
  endtask

  // One clock: compare outputs against the model at the negedge, then advance.
  task automatic cycle();
    int w;
    logic [NREQ-1:0]   e_gnt;
    logic [DWIDTH-1:0] e_din;
    @(negedge clk);
    w = model_winner();
    e_gnt = '0;
    e_din = '0;
    if (w >= 0) begin
      e_gnt[w] = 1'b1;
      e_din = bus.data[w*DWIDTH +: DWIDTH];
    end
    last_gnt   = bus.gnt;
    last_id    = bus.fifo_id;
    last_din   = bus.fifo_din;
    last_busy  = bus.busy;
    last_write = bus.fifo_write;
    chk("gnt", 64'(bus.gnt), 64'(e_gnt));
    chk("fifo_write", 64'(bus.fifo_write), 64'(w >= 0));
    chk("fifo_din", 64'(bus.fifo_din), 64'(e_din));
    chk("fifo_id", 64'(bus.fifo_id), (w >= 0) ? 64'(w) : 64'd0);
    chk("busy", 64'(bus.busy), 64'(m_locked));
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    chk("rst_gnt", 64'(bus.gnt), 64'd0);
    chk("rst_write", 64'(bus.fifo_write), 64'd0);
    chk("rst_din", 64'(bus.fifo_din), 64'd0);
    chk("rst_id", 64'(bus.fifo_id), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic rand_data();
    for (int j = 0; j < NREQ; j++) bus.data[j*DWIDTH +: DWIDTH] = $urandom;
  endtask

  initial begin
    bus.req = '0;
    bus.fifo_full = 1'b0;
    bus.data = '0;
    rand_data();

    // Reset with every requester active, then full-burst rotation.
    bus.req = 4'b1111;
    do_reset();
    for (int i = 0; i < 17; i++) begin
      cycle();
      if (i == 0) chk("first_gnt", 64'(last_gnt), 64'b0001);
      chk("rot_id", 64'(last_id), 64'((i / 4) % 4));
      chk("rot_write", 64'(last_write), 64'd1);
    end

    // Early drop: requester 1 takes two beats, drops, requester 2 waits one bubble.
    rand_data();
    bus.req = 4'b0000;
    do_reset();
    bus.req = 4'b0010;
    cycle();
    cycle();
    chk("drop_beat2", 64'(last_gnt), 64'b0010);
    bus.req = 4'b0100;
    cycle();
    chk("drop_bubble", 64'(last_gnt), 64'd0);
    cycle();
    chk("drop_next", 64'(last_gnt), 64'b0100);

    // Full stall: requester 3 locked with one beat, FIFO full for five cycles.
    bus.req = 4'b0000;
    do_reset();
    bus.req = 4'b1000;
    cycle();
    chk("stall_first", 64'(last_gnt), 64'b1000);
    bus.req = 4'b1001;
    bus.fifo_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("stall_gnt", 64'(last_gnt), 64'd0);
      chk("stall_busy", 64'(last_busy), 64'd1);
    end
    bus.fifo_full = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_resume", 64'(last_gnt), 64'b1000);
    end
    cycle();
    chk("stall_wrap", 64'(last_gnt), 64'b0001);

    // Sparse/wrap: burst of requester 2 leaves rr_ptr=3; it wins again via wrap.
    bus.req = 4'b0000;
    do_reset();
    rand_data();
    bus.req = 4'b0100;
    for (int i = 0; i < 4; i++) cycle();
    cycle();
    chk("sparse_gnt", 64'(last_gnt), 64'b0100);
    chk("sparse_din", 64'(last_din), 64'(bus.data[2*DWIDTH +: DWIDTH]));

    // Asynchronous reset pulse in the middle of a burst.
    bus.req = 4'b0000;
    do_reset();
    bus.req = 4'b0001;
    cycle();
    cycle();
    #2;
    chk("pre_arst_busy", 64'(bus.busy), 64'd1);
    chk("pre_arst_write", 64'(bus.fifo_write), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(bus.busy), 64'd0);
    chk("arst_gnt", 64'(bus.gnt), 64'd0);
    chk("arst_write", 64'(bus.fifo_write), 64'd0);
    model_reset();
    rst_n = 1'b1;
    bus.req = 4'b1111;
    cycle();
    chk("arst_restart", 64'(last_gnt), 64'b0001);

    // Randomized traffic including backpressure and dropped requests.
    bus.req = 4'b0000;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      bus.req = 4'($urandom);
      bus.fifo_full = ($urandom_range(0, 4) == 0);
      rand_data();
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
